w_stage_grf: RTL and testbench

//   Writeback-stage consumer of the M/W pipeline register outputs. Selects writeback data, writes the
//   32x32 general register file and serves the two D-stage read ports with same-cycle W->D bypass.

---
 rtl/grf_pkg.sv | 16 +
 rtl/wb_data_mux.sv | 25 ++
 rtl/w_stage_grf.sv | 88 ++++++++
 tb/tb_w_stage_grf.sv | 202 ++++++++++++++++++++
 4 files changed

// File: rtl/grf_pkg.sv
// Shared types and constants for the writeback stage and general register file.
package grf_pkg;

  typedef logic [4:0]  reg_addr_t;
  typedef logic [31:0] word_t;

  localparam logic [1:0] WB_SEL_ALU = 2'b00;
  localparam logic [1:0] WB_SEL_DM  = 2'b01;
  localparam logic [1:0] WB_SEL_PC8 = 2'b10;

  localparam reg_addr_t REG_ZERO = 5'd0;

  // Link address is the instruction after the delay slot.
  localparam word_t GRF_LINK_OFS_DEFAULT = 32'd8;

endpackage

// File: rtl/wb_data_mux.sv
// Writeback data select: ALU result, load data, link address or zero.
module wb_data_mux
  import grf_pkg::*;
#(
  parameter word_t LINK_OFS = GRF_LINK_OFS_DEFAULT
) (
  input  logic [1:0] sel,
  input  word_t      alu_out,
  input  word_t      dm_out,
  input  word_t      pc,
  output word_t      write_data
);

  // Pure combinational source select; link arithmetic wraps mod 2^32.
  always_comb begin
    write_data = '0;
    case (sel)
      WB_SEL_ALU: write_data = alu_out;
      WB_SEL_DM:  write_data = dm_out;
      WB_SEL_PC8: write_data = pc + LINK_OFS;
      default:    write_data = '0;
    endcase
  end

endmodule

// File: rtl/w_stage_grf.sv
// Writeback stage: data select, 32x32 register file with same-cycle W->D
// bypass, retired-instruction counter and sticky T_new error flag.
// Optional write tracing (simulation only) enabled by defining GRF_TRACE_EN.
module w_stage_grf
  import grf_pkg::*;
#(
  parameter int    NREG     = 32,
  parameter word_t LINK_OFS = GRF_LINK_OFS_DEFAULT
) (
  input  logic       clk,
  input  logic       reset,
  input  reg_addr_t  W_WriteRegAddr,
  input  word_t      W_ALU_out,
  input  word_t      W_DM_out,
  input  word_t      W_PC,
  input  logic       W_CU_EN_RegWrite,
  input  logic [1:0] W_CU_GRFWriteData_Sel,
  input  logic [1:0] W_T_new,
  input  reg_addr_t  D_rs_addr,
  input  reg_addr_t  D_rt_addr,
  output word_t      D_RD1,
  output word_t      D_RD2,
  output word_t      W_WriteData,
  output word_t      W_retired,
  output logic       W_tnew_err
);

  word_t grf_q [NREG];
  word_t grf_d [NREG];
  word_t retired_q, retired_d;
  logic  tnew_err_q, tnew_err_d;
  logic  wr_en;

  wb_data_mux #(
    .LINK_OFS (LINK_OFS)
  ) u_wb_data_mux (
    .sel        (W_CU_GRFWriteData_Sel),
    .alu_out    (W_ALU_out),
    .dm_out     (W_DM_out),
    .pc         (W_PC),
    .write_data (W_WriteData)
  );

  // $0 is hardwired, so a write to it is simply dropped.
  assign wr_en = W_CU_EN_RegWrite && (W_WriteRegAddr != REG_ZERO);

  // Next-state for the register file, counter and error flag.
  always_comb begin
    grf_d = grf_q;
    if (wr_en) grf_d[W_WriteRegAddr] = W_WriteData;
    retired_d  = (W_PC != '0) ? retired_q + 32'd1 : retired_q;
    tnew_err_d = tnew_err_q | (W_T_new != 2'b00);
  end

  // Reset clears all state; a write presented in the reset cycle is lost.
  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < NREG; i++) grf_q[i] <= '0;
      retired_q  <= '0;
      tnew_err_q <= 1'b0;
    end else begin
      grf_q      <= grf_d;
      retired_q  <= retired_d;
      tnew_err_q <= tnew_err_d;
    end
  end

  // Read ports: $0 reads zero, then same-cycle bypass from W, else the file.
  always_comb begin
    D_RD1 = grf_q[D_rs_addr];
    D_RD2 = grf_q[D_rt_addr];
    if (wr_en && D_rs_addr == W_WriteRegAddr) D_RD1 = W_WriteData;
    if (wr_en && D_rt_addr == W_WriteRegAddr) D_RD2 = W_WriteData;
    if (D_rs_addr == REG_ZERO) D_RD1 = '0;
    if (D_rt_addr == REG_ZERO) D_RD2 = '0;
  end

  assign W_retired  = retired_q;
  assign W_tnew_err = tnew_err_q;

`ifdef GRF_TRACE_EN
  // Trace every write that actually lands in the file.
  always_ff @(posedge clk) begin
    if (!reset && wr_en) $display("@%h: $%d <= %h", W_PC, W_WriteRegAddr, W_WriteData);
  end
`endif

endmodule

// File: tb/tb_w_stage_grf.sv
// Bench for w_stage_grf: directed scenarios with literal expectations plus a
// randomized run compared every cycle against a behavioural model.
module tb_w_stage_grf;

  logic        clk = 1'b0;
  logic        reset;
  logic [4:0]  W_WriteRegAddr;
  logic [31:0] W_ALU_out, W_DM_out, W_PC;
  logic        W_CU_EN_RegWrite;
  logic [1:0]  W_CU_GRFWriteData_Sel, W_T_new;
  logic [4:0]  D_rs_addr, D_rt_addr;
  logic [31:0] D_RD1, D_RD2, W_WriteData, W_retired;
  logic        W_tnew_err;

  int total = 0;
  int bad   = 0;

  // Behavioural model state
  logic [31:0] m_rf [32];
  logic [31:0] m_cnt;
  logic        m_err;
  logic        started = 1'b0;

  always #5 clk = ~clk;

  w_stage_grf dut (
    .clk                   (clk),
    .reset                 (reset),
    .W_WriteRegAddr        (W_WriteRegAddr),
    .W_ALU_out             (W_ALU_out),
    .W_DM_out              (W_DM_out),
    .W_PC                  (W_PC),
    .W_CU_EN_RegWrite      (W_CU_EN_RegWrite),
    .W_CU_GRFWriteData_Sel (W_CU_GRFWriteData_Sel),
    .W_T_new               (W_T_new),
    .D_rs_addr             (D_rs_addr),
    .D_rt_addr             (D_rt_addr),
    .D_RD1                 (D_RD1),
    .D_RD2                 (D_RD2),
    .W_WriteData           (W_WriteData),
    .W_retired             (W_retired),
    .W_tnew_err            (W_tnew_err)
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic [31:0] m_wdata();
    case (W_CU_GRFWriteData_Sel)
      2'd0:    return W_ALU_out;
      2'd1:    return W_DM_out;
      2'd2:    return W_PC + 32'd8;
      default: return 32'h0;
    endcase
  endfunction

  function automatic logic [31:0] m_read(input logic [4:0] a);
    if (a == 5'd0) return 32'h0;
    if (W_CU_EN_RegWrite && a == W_WriteRegAddr) return m_wdata();
    return m_rf[a];
  endfunction

  // Model update at the clock edge, from the inputs held stable across it.
  always @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < 32; i++) m_rf[i] = 32'h0;
      m_cnt   = 32'h0;
      m_err   = 1'b0;
      started = 1'b1;
    end else begin
      if (W_CU_EN_RegWrite && W_WriteRegAddr != 5'd0) m_rf[W_WriteRegAddr] = m_wdata();
      if (W_PC != 32'h0) m_cnt = m_cnt + 32'd1;
      if (W_T_new != 2'b00) m_err = 1'b1;
    end
  end

  // Compare process: every cycle once the model is defined.
  always @(negedge clk) begin
    if (started) begin
      check("mdl_rd1", D_RD1, m_read(D_rs_addr));
      check("mdl_rd2", D_RD2, m_read(D_rt_addr));
      check("mdl_wdata", W_WriteData, m_wdata());
      check("mdl_retired", W_retired, m_cnt);
      check("mdl_tnew_err", {31'h0, W_tnew_err}, {31'h0, m_err});
    end
  end

  task automatic next();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    W_CU_EN_RegWrite = 1'b0;
    W_PC             = 32'h0;
    W_T_new          = 2'b00;
  endtask

  initial begin
    reset = 1'b1;
    W_WriteRegAddr = 5'd0; W_ALU_out = 32'h0; W_DM_out = 32'h0; W_PC = 32'h0;
    W_CU_EN_RegWrite = 1'b0; W_CU_GRFWriteData_Sel = 2'b00; W_T_new = 2'b00;
    D_rs_addr = 5'd0; D_rt_addr = 5'd0;

    // 1: reset state
    next(); next();
    reset = 1'b0; D_rs_addr = 5'd5; D_rt_addr = 5'd31;
    @(negedge clk);
    check("rst_rd1", D_RD1, 32'h0);
    check("rst_rd2", D_RD2, 32'h0);
    check("rst_retired", W_retired, 32'h0);
    check("rst_err", {31'h0, W_tnew_err}, 32'h0);

    // 2: bypass then file read
    next();
    W_CU_GRFWriteData_Sel = 2'b00; W_ALU_out = 32'h1234_5678;
    W_WriteRegAddr = 5'd8; W_CU_EN_RegWrite = 1'b1; D_rs_addr = 5'd8;
    @(negedge clk); check("bypass_rd1", D_RD1, 32'h1234_5678);
    next(); W_CU_EN_RegWrite = 1'b0;
    @(negedge clk); check("file_rd1", D_RD1, 32'h1234_5678);

    // 3: link writeback to $31
    next();
    W_CU_GRFWriteData_Sel = 2'b10; W_PC = 32'h0000_3000;
    W_WriteRegAddr = 5'd31; W_CU_EN_RegWrite = 1'b1;
    @(negedge clk); check("link_wdata", W_WriteData, 32'h0000_3008);
    next(); idle(); D_rt_addr = 5'd31;
    @(negedge clk); check("link_rf31", D_RD2, 32'h0000_3008);
    check("retired_one", W_retired, 32'd1);

    // 4: $0 stays zero
    next();
    W_CU_GRFWriteData_Sel = 2'b00; W_ALU_out = 32'hDEAD_BEEF;
    W_WriteRegAddr = 5'd0; W_CU_EN_RegWrite = 1'b1; D_rs_addr = 5'd0;
    @(negedge clk); check("zero_same", D_RD1, 32'h0);
    next(); W_CU_EN_RegWrite = 1'b0;
    @(negedge clk); check("zero_next", D_RD1, 32'h0);

    // 5: retire count and sticky error
    next(); reset = 1'b1;
    next(); reset = 1'b0; W_PC = 32'h0000_3000;
    next(); next(); next(); W_PC = 32'h0;
    next(); next();
    @(negedge clk); check("retired_three", W_retired, 32'd3);
    W_T_new = 2'b01;
    next(); W_T_new = 2'b00;
    @(negedge clk); check("err_set", {31'h0, W_tnew_err}, 32'h1);
    next();
    @(negedge clk); check("err_held", {31'h0, W_tnew_err}, 32'h1);

    // 6: write lost in reset cycle; Sel=11 writes zero
    next();
    reset = 1'b1; W_CU_GRFWriteData_Sel = 2'b00; W_ALU_out = 32'hAAAA_AAAA;
    W_WriteRegAddr = 5'd9; W_CU_EN_RegWrite = 1'b1;
    next(); reset = 1'b0; W_CU_EN_RegWrite = 1'b0; D_rs_addr = 5'd9;
    @(negedge clk); check("rst_write_lost", D_RD1, 32'h0);
    check("err_cleared", {31'h0, W_tnew_err}, 32'h0);
    next();
    W_CU_GRFWriteData_Sel = 2'b11; W_ALU_out = 32'h5555_5555;
    W_WriteRegAddr = 5'd10; W_CU_EN_RegWrite = 1'b1; D_rt_addr = 5'd10;
    @(negedge clk); check("sel11_wdata", W_WriteData, 32'h0);
    next(); W_CU_EN_RegWrite = 1'b0;
    @(negedge clk); check("sel11_rf10", D_RD2, 32'h0);

    // PC+8 wraps mod 2^32
    next(); W_CU_GRFWriteData_Sel = 2'b10; W_PC = 32'hFFFF_FFFC;
    @(negedge clk); check("link_wrap", W_WriteData, 32'h0000_0004);

    // Dual bypass on both ports in the same cycle
    next(); W_CU_GRFWriteData_Sel = 2'b01; W_DM_out = 32'hCAFE_F00D; W_PC = 32'h0;
    W_WriteRegAddr = 5'd17; W_CU_EN_RegWrite = 1'b1; D_rs_addr = 5'd17; D_rt_addr = 5'd17;
    @(negedge clk); check("dual_rd1", D_RD1, 32'hCAFE_F00D);
    check("dual_rd2", D_RD2, 32'hCAFE_F00D);

    // Randomized run checked by the model
    for (int c = 0; c < 4000; c++) begin
      next();
      reset                 = ($urandom_range(0, 149) == 0);
      W_WriteRegAddr        = 5'($urandom_range(0, 31));
      W_ALU_out             = $urandom;
      W_DM_out              = $urandom;
      W_PC                  = ($urandom_range(0, 3) == 0) ? 32'h0 : $urandom;
      W_CU_EN_RegWrite      = $urandom_range(0, 1) == 1;
      W_CU_GRFWriteData_Sel = 2'($urandom_range(0, 3));
      W_T_new               = ($urandom_range(0, 199) == 0) ? 2'($urandom_range(1, 3)) : 2'b00;
      D_rs_addr = ($urandom_range(0, 3) == 0) ? W_WriteRegAddr : 5'($urandom_range(0, 31));
      D_rt_addr = ($urandom_range(0, 3) == 0) ? W_WriteRegAddr : 5'($urandom_range(0, 31));
    end
    next(); reset = 1'b0; idle();
    @(negedge clk);
    @(negedge clk);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
